calc_entry_sequencer: RTL and testbench
=======================================

Name: calc_entry_sequencer

Overview:
Controls keypad-driven calculator entry. It accumulates decimal digits into two operand registers, latches the operator key, and issues a one-cycle start to the shared ALU. It then waits for the ALU done handshake with a timeout and holds the result for display. It sits between the keypad decoder (key_code/key_valid) and the ALU/display datapath.

Parameters:
W, 16, operand and result width in bits
MAX_DIGITS, 4, maximum decimal digits per operand; further digits are ignored
TIMEOUT, 64, number of cycles in WAIT without alu_done before an abort

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
key_valid  input  1  one-cycle pulse: key_code/key_is_op valid this cycle
key_is_op  input  1  0 = digit key, 1 = operator/command key
key_code  input  4  digit 0-9, or op code: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MUL, E EQUALS, F CLEAR
alu_done  input  1  one-cycle pulse from ALU: result valid
alu_result  input  W  ALU result, sampled when alu_done=1
alu_flags  input  4  NZCV, sampled with alu_result
operand_a  output  W  first operand to ALU
operand_b  output  W  second operand to ALU
alu_op  output  4  latched operator code (0-5)
alu_start  output  1  one-cycle start pulse
result  output  W  latched ALU result
flags  output  4  latched NZCV
result_valid  output  1  result/flags are displayable
busy  output  1  high in EXEC and WAIT
timeout_err  output  1  sticky abort flag
state_dbg  output  3  current state encoding

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is asynchronous, active-high. On reset, all outputs are 0, state is IDLE, and the digit counter is 0.
- States: IDLE=0, ENTER_A=1, ENTER_B=2, EXEC=3, WAIT=4, SHOW=5. Codes 6-7 go to IDLE on the next clock.
- All outputs are registered. A key accepted at edge n updates its registers and state at edge n.
- Digit keys: key_code 10-15 with key_is_op=0 are ignored. Invalid op codes 6-D are ignored.
- Accumulation: operand <= operand*10 + digit, computed as (x<<3)+(x<<1)+d and truncated to W bits. It applies only while digit count < MAX_DIGITS; otherwise the key is ignored and the count saturates.
- IDLE:
  - digit: A=d, count=1, go to ENTER_A.
  - op: A=0, alu_op latched, B=0, count=0, go to ENTER_B.
  - EQUALS/CLEAR: stay in IDLE.
- ENTER_A:
  - digit: accumulate into A.
  - op: latch alu_op, B=0, count=0, go to ENTER_B.
  - EQUALS: ignored.
  - CLEAR: A, B, op and count cleared, go to IDLE.
- ENTER_B:
  - digit: accumulate into B.
  - op: overwrites alu_op, B unchanged.
  - EQUALS with count=0: ignored.
  - EQUALS with count>0: go to EXEC.
  - CLEAR: as in ENTER_A.
- EXEC: alu_start=1 for exactly this one cycle, then go to WAIT unconditionally. All keys are ignored. alu_done is not sampled; the ALU latency must be at least 1 cycle.
- WAIT:
  - A timeout counter starts at 0 on entry and increments each cycle.
  - alu_done: result<=alu_result, flags<=alu_flags, result_valid<=1, go to SHOW.
  - counter reaches TIMEOUT-1 without alu_done: timeout_err<=1, go to IDLE.
  - CLEAR: abort to IDLE. CLEAR wins over a simultaneous alu_done; that result is discarded.
  - Other keys are ignored.
- SHOW: result_valid=1.
  - digit: result_valid<=0, A=d, count=1, go to ENTER_A.
  - op: chain; A<=result, latch alu_op, B=0, count=0, result_valid<=0, go to ENTER_B.
  - EQUALS: ignored.
  - CLEAR: go to IDLE, result_valid<=0.
- alu_done outside WAIT is ignored with no state change.
- timeout_err clears on the next accepted key (any state) or on reset.
- busy = (state==EXEC) || (state==WAIT).
- A key_valid coincident with the EXEC entry edge is ignored.
- Reset mid-operation, including WAIT: immediate return to reset values. A later alu_done is ignored.

Test Plan:
- Keys 1,2,ADD,3,4,EQUALS; ALU model returns 46 three cycles after start -> operand_a=12, operand_b=34, alu_op=0; alu_start high exactly 1 cycle, the cycle after EQUALS; result=46, result_valid=1, state_dbg=5.
- MAX_DIGITS=4, keys 1,2,3,4,5 -> operand_a=1234, state ENTER_A; key_code 12 digit -> no change.
- From the SHOW result 46: SUB,6,EQUALS -> operand_a=46, operand_b=6, alu_op=1, result_valid drops at SUB and rises on the next alu_done.
- TIMEOUT=16, 5,ADD,5,EQUALS, ALU silent -> busy=1 for 17 cycles (EXEC+16 WAIT), then timeout_err=1, state IDLE; next digit key clears timeout_err.
- In WAIT, CLEAR and alu_done in the same cycle -> state IDLE, result_valid=0, result unchanged (0).
- Async reset asserted mid-WAIT between clock edges -> all outputs 0 before the next edge; a subsequent alu_done leaves state IDLE.

Source files
------------

// File: rtl/calc_entry_sequencer.sv
// Keypad entry sequencer for the calculator: builds two decimal operands, latches the
// operator, kicks the shared ALU, then waits (with timeout) and holds the result for display.
module calc_entry_sequencer #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic         key_is_op,
    input  logic [3:0]   key_code,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [3:0]   alu_op,
    output logic         alu_start,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         result_valid,
    output logic         busy,
    output logic         timeout_err,
    output logic [2:0]   state_dbg
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTER_A = 3'd1;
    localparam logic [2:0] S_ENTER_B = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_SHOW    = 3'd5;

    localparam logic [3:0] KEY_EQUALS = 4'hE;
    localparam logic [3:0] KEY_CLEAR  = 4'hF;
    localparam logic [3:0] OP_LAST    = 4'd5;
    localparam logic [3:0] DIGIT_LAST = 4'd9;

    localparam int CW = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [2:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [3:0]    r_op;
    logic [CW-1:0] r_count;
    logic [TW-1:0] r_tcnt;
    logic          r_start;
    logic [W-1:0]  r_result;
    logic [3:0]    r_flags;
    logic          r_rv;
    logic          r_busy;
    logic          r_terr;

    logic [2:0]    w_state;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic [3:0]    w_op;
    logic [CW-1:0] w_count;
    logic [TW-1:0] w_tcnt;
    logic          w_start;
    logic [W-1:0]  w_result;
    logic [3:0]    w_flags;
    logic          w_rv;
    logic          w_busy;
    logic          w_terr;

    logic          w_isDigit;
    logic          w_isOp;
    logic          w_isEquals;
    logic          w_isClear;
    logic          w_keyOk;
    logic          w_canAcc;
    logic [W-1:0]  w_digit;

    // x*10 + d built from shifts so no multiplier is inferred; wraps at W bits.
    function automatic logic [W-1:0] accumulate(input logic [W-1:0] x, input logic [W-1:0] d);
        return (x << 3) + (x << 1) + d;
    endfunction

    assign w_isDigit  = key_valid && !key_is_op && (key_code <= DIGIT_LAST);
    assign w_isOp     = key_valid &&  key_is_op && (key_code <= OP_LAST);
    assign w_isEquals = key_valid &&  key_is_op && (key_code == KEY_EQUALS);
    assign w_isClear  = key_valid &&  key_is_op && (key_code == KEY_CLEAR);
    assign w_keyOk    = w_isDigit || w_isOp || w_isEquals || w_isClear;
    assign w_canAcc   = (r_count < CW'(MAX_DIGITS));
    assign w_digit    = W'(key_code);

    always_comb begin
        w_state  = r_state;
        w_a      = r_a;
        w_b      = r_b;
        w_op     = r_op;
        w_count  = r_count;
        w_tcnt   = r_tcnt;
        w_start  = 1'b0;
        w_result = r_result;
        w_flags  = r_flags;
        w_rv     = r_rv;
        w_terr   = r_terr;

        // Any recognised key outside the ALU handshake acknowledges a previous timeout.
        if (w_keyOk && (r_state != S_EXEC) && (r_state != S_WAIT)) begin
            w_terr = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_isDigit) begin
                    w_a     = w_digit;
                    w_count = CW'(1);
                    w_state = S_ENTER_A;
                end else if (w_isOp) begin
                    w_a     = '0;
                    w_b     = '0;
                    w_op    = key_code;
                    w_count = '0;
                    w_state = S_ENTER_B;
                end
            end
            S_ENTER_A: begin
                if (w_isDigit) begin
                    if (w_canAcc) begin
                        w_a     = accumulate(r_a, w_digit);
                        w_count = r_count + CW'(1);
                    end
                end else if (w_isOp) begin
                    w_op    = key_code;
                    w_b     = '0;
                    w_count = '0;
                    w_state = S_ENTER_B;
                end else if (w_isClear) begin
                    w_a     = '0;
                    w_b     = '0;
                    w_op    = '0;
                    w_count = '0;
                    w_state = S_IDLE;
                end
            end
            S_ENTER_B: begin
                if (w_isDigit) begin
                    if (w_canAcc) begin
                        w_b     = accumulate(r_b, w_digit);
                        w_count = r_count + CW'(1);
                    end
                end else if (w_isOp) begin
                    w_op = key_code;
                end else if (w_isEquals) begin
                    if (r_count != '0) begin
                        w_start = 1'b1;
                        w_state = S_EXEC;
                    end
                end else if (w_isClear) begin
                    w_a     = '0;
                    w_b     = '0;
                    w_op    = '0;
                    w_count = '0;
                    w_state = S_IDLE;
                end
            end
            S_EXEC: begin
                w_tcnt  = '0;
                w_state = S_WAIT;
            end
            S_WAIT: begin
                // CLEAR is checked first so an abort discards a same-cycle result.
                if (w_isClear) begin
                    w_state = S_IDLE;
                end else if (alu_done) begin
                    w_result = alu_result;
                    w_flags  = alu_flags;
                    w_rv     = 1'b1;
                    w_state  = S_SHOW;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_terr  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_tcnt = r_tcnt + TW'(1);
                end
            end
            S_SHOW: begin
                if (w_isDigit) begin
                    w_rv    = 1'b0;
                    w_a     = w_digit;
                    w_count = CW'(1);
                    w_state = S_ENTER_A;
                end else if (w_isOp) begin
                    w_a     = r_result;
                    w_b     = '0;
                    w_op    = key_code;
                    w_count = '0;
                    w_rv    = 1'b0;
                    w_state = S_ENTER_B;
                end else if (w_isClear) begin
                    w_rv    = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state == S_EXEC) || (w_state == S_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_count  <= '0;
            r_tcnt   <= '0;
            r_start  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_rv     <= 1'b0;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_a      <= w_a;
            r_b      <= w_b;
            r_op     <= w_op;
            r_count  <= w_count;
            r_tcnt   <= w_tcnt;
            r_start  <= w_start;
            r_result <= w_result;
            r_flags  <= w_flags;
            r_rv     <= w_rv;
            r_busy   <= w_busy;
            r_terr   <= w_terr;
        end
    end

    assign operand_a    = r_a;
    assign operand_b    = r_b;
    assign alu_op       = r_op;
    assign alu_start    = r_start;
    assign result       = r_result;
    assign flags        = r_flags;
    assign result_valid = r_rv;
    assign busy         = r_busy;
    assign timeout_err  = r_terr;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer: a behavioural ALU answers start pulses, and
// queued operand/result expectations are checked as the sequencer emits them.
module tb_calc_entry_sequencer;

    localparam int W   = 16;
    localparam int TMO = 16;

    localparam logic [3:0] K_ADD = 4'd0;
    localparam logic [3:0] K_SUB = 4'd1;
    localparam logic [3:0] K_EQ  = 4'hE;
    localparam logic [3:0] K_CLR = 4'hF;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_is_op = 1'b0;
    logic [3:0]   key_code  = 4'd0;

    logic         autoDone  = 1'b0;
    logic [W-1:0] autoRes   = '0;
    logic [3:0]   autoFlags = '0;
    logic         manDone   = 1'b0;
    logic [W-1:0] manRes    = '0;

    wire          alu_done   = autoDone | manDone;
    wire [W-1:0]  alu_result = manDone ? manRes : autoRes;
    wire [3:0]    alu_flags  = manDone ? 4'hF : autoFlags;

    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [3:0]   alu_op;
    logic         alu_start;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         result_valid;
    logic         busy;
    logic         timeout_err;
    logic [2:0]   state_dbg;

    calc_entry_sequencer #(.W(W), .MAX_DIGITS(4), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_is_op    (key_is_op),
        .key_code     (key_code),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .alu_op       (alu_op),
        .alu_start    (alu_start),
        .result       (result),
        .flags        (flags),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
    } startExp_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;
    } resExp_t;

    startExp_t startQ[$];
    resExp_t   resultQ[$];
    startExp_t se;
    resExp_t   re;

    int   errors    = 0;
    int   checks    = 0;
    bit   aluSilent = 1'b0;
    int   aluCnt    = 0;
    int   busyCnt;
    logic prevStart = 1'b0;
    logic prevRv    = 1'b0;

    function automatic logic [W-1:0] aluModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a * b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [3:0] flagsOf(input logic [W-1:0] r);
        return {r[W-1], (r == '0), 2'b00};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic isOp, input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_is_op = isOp;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_is_op = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic expectExec(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [3:0] op, input bit withResult);
        startExp_t s;
        resExp_t   r;
        s.a  = a;
        s.b  = b;
        s.op = op;
        startQ.push_back(s);
        if (withResult) begin
            r.res = aluModel(a, b, op);
            r.fl  = flagsOf(r.res);
            resultQ.push_back(r);
        end
    endtask

    task automatic waitState(input string tag, input logic [2:0] target, input int limit);
        for (int i = 0; i < limit && state_dbg !== target; i++) @(negedge clk);
        checkOutput(tag, state_dbg, target);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Behavioural ALU: answers a start pulse three cycles later unless silenced.
    always @(negedge clk) begin
        if (alu_start && !aluSilent) begin
            aluCnt    <= 3;
            autoRes   <= aluModel(operand_a, operand_b, alu_op);
            autoFlags <= flagsOf(aluModel(operand_a, operand_b, alu_op));
            autoDone  <= 1'b0;
        end else if (aluCnt > 0) begin
            aluCnt   <= aluCnt - 1;
            autoDone <= (aluCnt == 1);
        end else begin
            autoDone <= 1'b0;
        end
    end

    // Scoreboard: start pulses and result_valid rises consume queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_start) begin
                if (prevStart) checkOutput("startWidth", 64'd2, 64'd1);
                if (startQ.size() == 0) begin
                    checkOutput("startSpurious", 64'd1, 64'd0);
                end else begin
                    se = startQ.pop_front();
                    checkOutput("sbOperandA", operand_a, se.a);
                    checkOutput("sbOperandB", operand_b, se.b);
                    checkOutput("sbAluOp", alu_op, se.op);
                end
            end
            if (result_valid && !prevRv) begin
                if (resultQ.size() == 0) begin
                    checkOutput("resultSpurious", 64'd1, 64'd0);
                end else begin
                    re = resultQ.pop_front();
                    checkOutput("sbResult", result, re.res);
                    checkOutput("sbFlags", flags, re.fl);
                end
            end
        end
        prevStart <= alu_start;
        prevRv    <= result_valid;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", {operand_a, operand_b, alu_op, alu_start, result, flags,
                                     result_valid, busy, timeout_err, state_dbg}, 64'd0);
        reset = 1'b0;

        // 12 + 34 with the ALU answering after three cycles
        applyStimulus(1'b0, 4'd1);
        checkOutput("idleDigitState", state_dbg, 3'd1);
        checkOutput("idleDigitA", operand_a, 64'd1);
        applyStimulus(1'b0, 4'd2);
        checkOutput("accA12", operand_a, 64'd12);
        applyStimulus(1'b1, K_ADD);
        checkOutput("addState", state_dbg, 3'd2);
        checkOutput("addOperandB", operand_b, 64'd0);
        applyStimulus(1'b0, 4'd3);
        applyStimulus(1'b0, 4'd4);
        checkOutput("accB34", operand_b, 64'd34);
        expectExec(16'd12, 16'd34, K_ADD, 1'b1);
        applyStimulus(1'b1, K_EQ);
        checkOutput("startAfterEq", alu_start, 64'd1);
        checkOutput("execBusy", busy, 64'd1);
        @(negedge clk);
        checkOutput("startDrop", alu_start, 64'd0);
        checkOutput("waitEntered", state_dbg, 3'd4);
        waitState("showState", 3'd5, 20);
        checkOutput("result46", result, 64'd46);
        checkOutput("resultValid", result_valid, 64'd1);

        // chain: SUB 6 on top of the shown result
        applyStimulus(1'b1, K_SUB);
        checkOutput("chainA", operand_a, 64'd46);
        checkOutput("chainOp", alu_op, 64'd1);
        checkOutput("chainRvDrop", result_valid, 64'd0);
        checkOutput("chainState", state_dbg, 3'd2);
        applyStimulus(1'b0, 4'd6);
        expectExec(16'd46, 16'd6, K_SUB, 1'b1);
        applyStimulus(1'b1, K_EQ);
        waitState("chainShow", 3'd5, 20);
        checkOutput("result40", result, 64'd40);
        checkOutput("chainRvRise", result_valid, 64'd1);

        // digit limit, illegal keys, EQUALS without second operand
        applyStimulus(1'b1, K_CLR);
        checkOutput("clearFromShow", {state_dbg, result_valid}, 64'd0);
        for (int d = 1; d <= 5; d++) applyStimulus(1'b0, 4'(d));
        checkOutput("maxDigitsA", operand_a, 64'd1234);
        checkOutput("maxDigitsState", state_dbg, 3'd1);
        applyStimulus(1'b0, 4'd12);
        checkOutput("badDigitIgnored", operand_a, 64'd1234);
        applyStimulus(1'b1, 4'd8);
        checkOutput("badOpIgnored", state_dbg, 3'd1);
        applyStimulus(1'b1, K_ADD);
        applyStimulus(1'b1, K_EQ);
        checkOutput("eqNoDigits", state_dbg, 3'd2);
        applyStimulus(1'b1, K_CLR);
        checkOutput("clearEnterB", {state_dbg, operand_a, operand_b, alu_op}, 64'd0);

        // silent ALU: EXEC plus TIMEOUT wait cycles, then abort
        aluSilent = 1'b1;
        applyStimulus(1'b0, 4'd5);
        applyStimulus(1'b1, K_ADD);
        applyStimulus(1'b0, 4'd5);
        expectExec(16'd5, 16'd5, K_ADD, 1'b0);
        applyStimulus(1'b1, K_EQ);
        busyCnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busyCnt++;
            @(negedge clk);
        end
        checkOutput("busyCycles", busyCnt, 64'd17);
        checkOutput("timeoutFlag", timeout_err, 64'd1);
        checkOutput("timeoutState", state_dbg, 3'd0);
        applyStimulus(1'b0, 4'd3);
        checkOutput("timeoutCleared", timeout_err, 64'd0);
        checkOutput("afterTimeoutA", {state_dbg, operand_a}, {3'd1, 16'd3});
        applyStimulus(1'b1, K_CLR);

        // CLEAR and alu_done in the same WAIT cycle
        doReset();
        applyStimulus(1'b0, 4'd2);
        applyStimulus(1'b1, K_ADD);
        applyStimulus(1'b0, 4'd3);
        expectExec(16'd2, 16'd3, K_ADD, 1'b0);
        applyStimulus(1'b1, K_EQ);
        @(negedge clk);
        key_valid = 1'b1;
        key_is_op = 1'b1;
        key_code  = K_CLR;
        manDone   = 1'b1;
        manRes    = 16'd99;
        @(negedge clk);
        key_valid = 1'b0;
        key_is_op = 1'b0;
        key_code  = 4'd0;
        manDone   = 1'b0;
        checkOutput("clrWinsState", state_dbg, 3'd0);
        checkOutput("clrWinsRv", result_valid, 64'd0);
        checkOutput("clrWinsResult", result, 64'd0);

        // asynchronous reset in the middle of WAIT
        applyStimulus(1'b0, 4'd8);
        applyStimulus(1'b1, K_ADD);
        applyStimulus(1'b0, 4'd1);
        expectExec(16'd8, 16'd1, K_ADD, 1'b0);
        applyStimulus(1'b1, K_EQ);
        @(negedge clk);
        checkOutput("inWait", state_dbg, 3'd4);
        #2 reset = 1'b1;
        #1 checkOutput("asyncReset", {operand_a, operand_b, alu_op, alu_start, result, flags,
                                      result_valid, busy, timeout_err, state_dbg}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        manDone = 1'b1;
        manRes  = 16'd77;
        @(negedge clk);
        manDone = 1'b0;
        checkOutput("lateDoneState", state_dbg, 3'd0);
        checkOutput("lateDoneResult", {result_valid, result}, 64'd0);

        checkOutput("startQEmpty", startQ.size(), 64'd0);
        checkOutput("resultQEmpty", resultQ.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
